axis_broadcast_3: RTL and testbench

//   Upstream fan-out stage for axis_majority_vote: takes one AXI-Stream of feature/sample words
//   and delivers every beat, unchanged, to three classifier branches. Branches may accept at

---
 rtl/axis_broadcast_3_pkg.sv | 19 +
 rtl/axis_broadcast_3.sv | 111 +++++++++++
 tb/tb_axis_broadcast_3.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axis_broadcast_3_pkg.sv
// Shared definitions for the axis_broadcast_3 fan-out stage.
//   NUM_BRANCHES        number of downstream classifier branches
//   DEF_DATA_WIDTH      default tdata width (matches axis_majority_vote)
//   DEF_COUNT_WIDTH     default width of the debug beat/frame counters
//   drop_taken()        clears the pending bit of every branch that is ready
package axis_broadcast_3_pkg;

    localparam int unsigned NUM_BRANCHES    = 3;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_COUNT_WIDTH = 32;

    function automatic logic [NUM_BRANCHES-1:0] drop_taken(
        input logic [NUM_BRANCHES-1:0] pend,
        input logic [NUM_BRANCHES-1:0] ready
    );
        return pend & ~ready;
    endfunction

endpackage

// File: rtl/axis_broadcast_3.sv
// AXI-Stream 1-to-3 broadcast. Each accepted input beat is held in one register
// and presented to three branches; a branch sees tvalid only until it has taken
// the beat. The input is released once every branch has taken it.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  upstream stream
//   m_axis_t*_0/1/2                   branch streams (shared data/last register)
//   beat_count                        accepted input beats, wraps
//   frame_count                       accepted input beats with tlast, wraps
module axis_broadcast_3
    import axis_broadcast_3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata_0,
    output logic                   m_axis_tvalid_0,
    input  logic                   m_axis_tready_0,
    output logic                   m_axis_tlast_0,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata_1,
    output logic                   m_axis_tvalid_1,
    input  logic                   m_axis_tready_1,
    output logic                   m_axis_tlast_1,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata_2,
    output logic                   m_axis_tvalid_2,
    input  logic                   m_axis_tready_2,
    output logic                   m_axis_tlast_2,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    logic [DATA_WIDTH-1:0]   buf_data_q,    buf_data_d;
    logic                    buf_last_q,    buf_last_d;
    logic                    buf_valid_q,   buf_valid_d;
    logic [NUM_BRANCHES-1:0] pend_q,        pend_d;
    logic [COUNT_WIDTH-1:0]  beat_count_q,  beat_count_d;
    logic [COUNT_WIDTH-1:0]  frame_count_q, frame_count_d;

    logic [NUM_BRANCHES-1:0] tready_vec;
    logic                    done;
    logic                    s_fire;

    assign tready_vec = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

    // Every branch still pending is ready now, so the beat is fully delivered.
    assign done          = buf_valid_q & (drop_taken(pend_q, tready_vec) == '0);
    assign s_axis_tready = ~buf_valid_q | done;
    assign s_fire        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        buf_data_d    = buf_data_q;
        buf_last_d    = buf_last_q;
        buf_valid_d   = buf_valid_q;
        pend_d        = pend_q;
        beat_count_d  = beat_count_q;
        frame_count_d = frame_count_q;
        if (s_fire) begin
            // A new beat overrides release of the old one in the same cycle.
            buf_data_d   = s_axis_tdata;
            buf_last_d   = s_axis_tlast;
            buf_valid_d  = 1'b1;
            pend_d       = '1;
            beat_count_d = beat_count_q + 1'b1;
            if (s_axis_tlast) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end else if (done) begin
            buf_valid_d = 1'b0;
            pend_d      = '0;
        end else begin
            pend_d = drop_taken(pend_q, tready_vec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q    <= '0;
            buf_last_q    <= 1'b0;
            buf_valid_q   <= 1'b0;
            pend_q        <= '0;
            beat_count_q  <= '0;
            frame_count_q <= '0;
        end else begin
            buf_data_q    <= buf_data_d;
            buf_last_q    <= buf_last_d;
            buf_valid_q   <= buf_valid_d;
            pend_q        <= pend_d;
            beat_count_q  <= beat_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_tvalid_0 = buf_valid_q & pend_q[0];
    assign m_axis_tvalid_1 = buf_valid_q & pend_q[1];
    assign m_axis_tvalid_2 = buf_valid_q & pend_q[2];
    assign m_axis_tdata_0  = buf_data_q;
    assign m_axis_tdata_1  = buf_data_q;
    assign m_axis_tdata_2  = buf_data_q;
    assign m_axis_tlast_0  = buf_last_q;
    assign m_axis_tlast_1  = buf_last_q;
    assign m_axis_tlast_2  = buf_last_q;
    assign beat_count      = beat_count_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_axis_broadcast_3.sv
// Directed bench for axis_broadcast_3 (COUNT_WIDTH=4 so counter wrap is reachable).
module tb_axis_broadcast_3;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata_0, m_tdata_1, m_tdata_2;
    logic          m_tvalid_0, m_tvalid_1, m_tvalid_2;
    logic          m_tready_0, m_tready_1, m_tready_2;
    logic          m_tlast_0, m_tlast_1, m_tlast_2;
    logic [CW-1:0] beat_count, frame_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_broadcast_3 #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .s_axis_tlast    (s_tlast),
        .m_axis_tdata_0  (m_tdata_0),
        .m_axis_tvalid_0 (m_tvalid_0),
        .m_axis_tready_0 (m_tready_0),
        .m_axis_tlast_0  (m_tlast_0),
        .m_axis_tdata_1  (m_tdata_1),
        .m_axis_tvalid_1 (m_tvalid_1),
        .m_axis_tready_1 (m_tready_1),
        .m_axis_tlast_1  (m_tlast_1),
        .m_axis_tdata_2  (m_tdata_2),
        .m_axis_tvalid_2 (m_tvalid_2),
        .m_axis_tready_2 (m_tready_2),
        .m_axis_tlast_2  (m_tlast_2),
        .beat_count      (beat_count),
        .frame_count     (frame_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the three tvalids and shared data/last seen by valid branches.
    task automatic chk_out(input string tag, input logic [2:0] vexp,
                           input logic [DW-1:0] dexp, input logic lexp);
        chk({tag, ".tvalid"}, {m_tvalid_2, m_tvalid_1, m_tvalid_0}, vexp);
        if (vexp[0]) chk({tag, ".tdata0"}, m_tdata_0, dexp);
        if (vexp[1]) chk({tag, ".tdata1"}, m_tdata_1, dexp);
        if (vexp[2]) chk({tag, ".tdata2"}, m_tdata_2, dexp);
        if (vexp != 3'b000) chk({tag, ".tlast"}, {m_tlast_2, m_tlast_1, m_tlast_0}, {3{lexp}});
    endtask

    task automatic set_ready(input logic r2, input logic r1, input logic r0);
        m_tready_2 = r2;
        m_tready_1 = r1;
        m_tready_0 = r0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".tvalid"}, {m_tvalid_2, m_tvalid_1, m_tvalid_0}, 3'b000);
        chk({tag, ".tdata"}, {m_tdata_2, m_tdata_1, m_tdata_0}, '0);
        chk({tag, ".tlast"}, {m_tlast_2, m_tlast_1, m_tlast_0}, 3'b000);
        chk({tag, ".s_tready"}, s_tready, 1'b1);
        chk({tag, ".beat_count"}, beat_count, 4'd0);
        chk({tag, ".frame_count"}, frame_count, 4'd0);
    endtask

    initial begin
        // 1: reset
        rst_n = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        chk_reset_state("reset");
        rst_n = 1'b1;
        cyc();

        // 2: full rate, three beats back-to-back
        s_tvalid = 1'b1; s_tdata = 32'h11; s_tlast = 1'b0;
        #1 chk("full.s_tready_idle", s_tready, 1'b1);
        cyc();
        s_tdata = 32'h22;
        #1 chk_out("full.b0", 3'b111, 32'h11, 1'b0);
        chk("full.s_tready_b0", s_tready, 1'b1);
        cyc();
        s_tdata = 32'h33; s_tlast = 1'b1;
        #1 chk_out("full.b1", 3'b111, 32'h22, 1'b0);
        cyc();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1 chk_out("full.b2", 3'b111, 32'h33, 1'b1);
        cyc();
        chk_out("full.idle", 3'b000, '0, 1'b0);
        chk("full.beat_count", beat_count, 4'd3);
        chk("full.frame_count", frame_count, 4'd1);

        // 3: ready skew - branch1 takes after 3 cycles, branch2 after 5
        set_ready(1'b0, 1'b0, 1'b1);
        s_tvalid = 1'b1; s_tdata = 32'hA5;
        cyc();                                  // A5 loaded, c1
        s_tdata = 32'h5A;
        #1 chk_out("skew.c1", 3'b111, 32'hA5, 1'b0);
        chk("skew.c1.s_tready", s_tready, 1'b0);
        cyc();                                  // c2: branch0 done
        chk_out("skew.c2", 3'b110, 32'hA5, 1'b0);
        chk("skew.c2.s_tready", s_tready, 1'b0);
        cyc();                                  // c3
        chk_out("skew.c3", 3'b110, 32'hA5, 1'b0);
        cyc();                                  // c4: branch1 ready
        m_tready_1 = 1'b1;
        #1 chk_out("skew.c4", 3'b110, 32'hA5, 1'b0);
        chk("skew.c4.s_tready", s_tready, 1'b0);
        cyc();                                  // c5: only branch2 left
        chk_out("skew.c5", 3'b100, 32'hA5, 1'b0);
        chk("skew.c5.s_tready", s_tready, 1'b0);
        cyc();                                  // c6: branch2 ready, 5A accepted
        m_tready_2 = 1'b1;
        #1 chk_out("skew.c6", 3'b100, 32'hA5, 1'b0);
        chk("skew.c6.s_tready", s_tready, 1'b1);
        cyc();                                  // c7: 5A on all branches
        set_ready(1'b0, 1'b1, 1'b1);
        s_tvalid = 1'b0;
        #1 chk_out("skew.c7", 3'b111, 32'h5A, 1'b0);

        // 4: coincident release and load, pend=100
        cyc();
        chk_out("coin.pend100", 3'b100, 32'h5A, 1'b0);
        chk("coin.s_tready_stall", s_tready, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'hBEEF; m_tready_2 = 1'b1;
        #1 chk("coin.s_tready", s_tready, 1'b1);
        cyc();
        s_tvalid = 1'b0;
        #1 chk_out("coin.beef", 3'b111, 32'hBEEF, 1'b0);
        cyc();
        chk_out("coin.idle", 3'b000, '0, 1'b0);
        chk("coin.beat_count", beat_count, 4'd6);
        chk("coin.frame_count", frame_count, 4'd1);

        // 5: counter wrap with 4-bit counters, 17 tlast beats from reset
        rst_n = 1'b0;
        #1 chk_reset_state("wrap.reset");
        cyc();
        rst_n = 1'b1;
        cyc();
        s_tvalid = 1'b1; s_tlast = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_tdata = 32'h100 + i;
            cyc();
            chk("wrap.beat_count", beat_count, (i + 1) % 16);
            chk("wrap.frame_count", frame_count, (i + 1) % 16);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk_out("wrap.last_beat", 3'b111, 32'h110, 1'b1);
        cyc();

        // 6: reset while a beat is partly delivered
        set_ready(1'b0, 1'b0, 1'b1);
        s_tvalid = 1'b1; s_tdata = 32'h77;
        cyc();
        s_tvalid = 1'b0;
        #1 chk_out("mid.load", 3'b111, 32'h77, 1'b0);
        cyc();
        chk_out("mid.partial", 3'b110, 32'h77, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("mid.async");
        cyc();
        rst_n = 1'b1;
        set_ready(1'b1, 1'b1, 1'b1);
        cyc();
        chk_out("mid.after1", 3'b000, '0, 1'b0);
        chk("mid.after1.tdata", m_tdata_1, '0);
        cyc();
        chk_out("mid.after2", 3'b000, '0, 1'b0);
        chk("mid.after2.beat_count", beat_count, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
